// File: rtl/thermo_position_decoder.sv
// Thermometer-coded bar reader: synchronise, debounce, validate and hand out position 0..N.
// Optional TOLERANT_DECODE_EN: malformed codes still emit highest-set-bit+1 alongside code_err.
module thermo_position_decoder #(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int POS_W          = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     sw_in,
    output logic [POS_W-1:0] pos,
    output logic             pos_valid,
    input  logic             pos_ready,
    output logic             code_err
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        EMIT
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    state_t           state, state_next;
    logic [N-1:0]     sync1, sw_s;
    logic [N-1:0]     last_stable, last_stable_next;
    logic [N-1:0]     cand, cand_next;
    logic [15:0]      cnt, cnt_next;
    logic [POS_W-1:0] pos_next;
    logic             code_err_next;

    function automatic logic is_thermo(input logic [N-1:0] c);
        logic seen_zero;
        is_thermo = 1'b1;
        seen_zero = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!c[i]) seen_zero = 1'b1;
            else if (seen_zero) is_thermo = 1'b0;
        end
    endfunction

    // For a valid code this is also the number of lit segments.
    function automatic logic [POS_W-1:0] msb_pos(input logic [N-1:0] c);
        msb_pos = '0;
        for (int i = 0; i < N; i++) begin
            if (c[i]) msb_pos = POS_W'(i + 1);
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= '0;
            sw_s        <= '0;
            state       <= IDLE;
            last_stable <= '0;
            cand        <= '0;
            cnt         <= '0;
            pos         <= '0;
            code_err    <= 1'b0;
        end else begin
            sync1       <= sw_in;
            sw_s        <= sync1;
            state       <= state_next;
            last_stable <= last_stable_next;
            cand        <= cand_next;
            cnt         <= cnt_next;
            pos         <= pos_next;
            code_err    <= code_err_next;
        end
    end

    always_comb begin
        state_next       = state;
        last_stable_next = last_stable;
        cand_next        = cand;
        cnt_next         = cnt;
        pos_next         = pos;
        code_err_next    = 1'b0;

        case (state)
            IDLE: begin
                if (sw_s != last_stable) begin
                    state_next = SETTLE;
                    cand_next  = sw_s;
                    cnt_next   = '0;
                end
            end
            SETTLE: begin
                if (sw_s != cand) begin
                    cand_next = sw_s;
                    cnt_next  = '0;
                end else if (cnt == CNT_LAST) begin
                    last_stable_next = cand;
                    // A bounce that settled back on the old value is not a change.
                    if (cand == last_stable) begin
                        state_next = IDLE;
                    end else if (is_thermo(cand)) begin
                        state_next = EMIT;
                        pos_next   = msb_pos(cand);
                    end else begin
                        code_err_next = 1'b1;
`ifdef TOLERANT_DECODE_EN
                        state_next    = EMIT;
                        pos_next      = msb_pos(cand);
`else
                        state_next    = IDLE;
`endif
                    end
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            EMIT: begin
                if (pos_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign pos_valid = (state == EMIT);

endmodule

// File: tb/tb_thermo_position_decoder.sv
// Scoreboard bench for thermo_position_decoder: directed scenarios plus randomized bar patterns.
// Honours TOLERANT_DECODE_EN in its reference model.
module tb_thermo_position_decoder;

    localparam int N     = 8;
    localparam int D     = 4;
    localparam int POS_W = 4;

    typedef struct packed {
        logic             is_err;
        logic [POS_W-1:0] pos;
    } event_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     sw_in;
    logic [POS_W-1:0] pos;
    logic             pos_valid;
    logic             pos_ready;
    logic             code_err;

    event_t       expq[$];
    logic [N-1:0] modelStable;
    int           testsRun    = 0;
    int           testsFailed = 0;

    always #5 clk = ~clk;

    thermo_position_decoder #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_in    (sw_in),
        .pos      (pos),
        .pos_valid(pos_valid),
        .pos_ready(pos_ready),
        .code_err (code_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: a settled change to a new value yields one event, derived arithmetically.
    task automatic modelSettle(input logic [N-1:0] v);
        int ones;
        if (v != modelStable) begin
            ones = $countones(v);
            if (int'(v) == (1 << ones) - 1) begin
                expq.push_back('{is_err: 1'b0, pos: POS_W'(ones)});
            end else begin
                expq.push_back('{is_err: 1'b1, pos: '0});
`ifdef TOLERANT_DECODE_EN
                expq.push_back('{is_err: 1'b0, pos: POS_W'($clog2(int'(v) + 1))});
`endif
            end
            modelStable = v;
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input int cycles, input bit settles);
        sw_in = v;
        if (settles) modelSettle(v);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic waitValid(input string name);
        int n;
        n = 0;
        while (!pos_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, pos_valid, 1);
    endtask

    always @(negedge clk) begin
        event_t e;
        if (code_err) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected code_err", code_err, 0);
            end else begin
                e = expq.pop_front();
                checkOutput("code_err expected", e.is_err, 1);
            end
        end
        if (pos_valid && pos_ready) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected pos_valid", pos_valid, 0);
            end else begin
                e = expq.pop_front();
                checkOutput("pos_valid expected", e.is_err, 0);
                checkOutput("pos value", pos, e.pos);
            end
        end
    end

    initial begin
        int held;
        logic [8:0]   t9;
        logic [N-1:0] v;

        rst         = 1'b1;
        sw_in       = '0;
        pos_ready   = 1'b1;
        modelStable = '0;
        @(posedge clk);
        #1;
        checkOutput("reset pos", pos, 0);
        checkOutput("reset pos_valid", pos_valid, 0);
        checkOutput("reset code_err", code_err, 0);
        rst = 1'b0;
        applyStimulus(8'h00, 6, 0);

        // Latency: first sampling edge is t, pos_valid must rise exactly at t+D+2.
        sw_in = 8'h3F;
        modelSettle(8'h3F);
        repeat (D + 2) @(posedge clk);
        #1;
        checkOutput("latency early pos_valid", pos_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("latency pos_valid", pos_valid, 1);
        checkOutput("latency pos", pos, 6);
        @(posedge clk);
        #1;
        checkOutput("pulse width pos_valid", pos_valid, 0);
        applyStimulus(8'h3F, 6, 0);

        pos_ready = 1'b0;
        sw_in     = 8'h07;
        modelSettle(8'h07);
        waitValid("stall pos_valid timeout");
        held = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (pos_valid && pos == 4'd3) held++;
        end
        checkOutput("held while stalled", held, 10);
        pos_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("pos_valid after accept", pos_valid, 0);
        applyStimulus(8'h07, 8, 0);

        applyStimulus(8'h00, 12, 1);
        applyStimulus(8'h01, 2, 0);
        applyStimulus(8'h00, 12, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'h01, 3, 0);
            applyStimulus(8'h00, 3, 0);
        end
        applyStimulus(8'h00, 12, 0);

        applyStimulus(8'h05, 14, 1);
        applyStimulus(8'h00, 14, 1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                v = modelStable ^ (8'd1 << $urandom_range(0, 7));
                applyStimulus(v, $urandom_range(1, 3), 0);
                applyStimulus(modelStable, 12, 0);
            end else begin
                if ($urandom_range(0, 2) != 0) begin
                    t9 = (9'd1 << $urandom_range(0, 8)) - 9'd1;
                    v  = t9[7:0];
                end else begin
                    v = 8'($urandom_range(0, 255));
                end
                applyStimulus(v, $urandom_range(10, 14), 1);
            end
        end
        applyStimulus(modelStable, 12, 0);

        pos_ready = 1'b0;
        sw_in     = 8'hFF;
        modelSettle(8'hFF);
        waitValid("pre-reset pos_valid timeout");
        rst = 1'b1;
        expq.delete();
        modelStable = '0;
        @(posedge clk);
        #1;
        checkOutput("mid-reset pos_valid", pos_valid, 0);
        checkOutput("mid-reset pos", pos, 0);
        checkOutput("mid-reset code_err", code_err, 0);
        rst       = 1'b0;
        pos_ready = 1'b1;
        modelSettle(8'hFF);
        applyStimulus(8'hFF, 14, 0);

        repeat (20) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
